// File: rtl/vga_timing_generator.sv
// VGA raster generator: pixel/line counters, 1-based visible coordinates,
// registered blanked color, registered syncs and a once-per-frame tick.
module vga_timing_generator #(
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic        CLOCK_25,
  input  logic        RESET,
  input  logic [2:0]  color_in,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        active,
  output logic [2:0]  rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_tick
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] H_VIS_C  = 12'(H_VISIBLE);
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] HS_START = 12'(H_VISIBLE + H_FRONT);
  localparam logic [11:0] HS_END   = 12'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [11:0] V_VIS_C  = 12'(V_VISIBLE);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] VS_START = 12'(V_VISIBLE + V_FRONT);
  localparam logic [11:0] VS_END   = 12'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [11:0] V_TICK   = 12'(V_VISIBLE - 1);

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic [2:0]  rgb_q, rgb_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        tick_q, tick_d;
  logic        h_active, v_active, h_last, v_last;

  always_comb begin
    h_active = (h_cnt_q < H_VIS_C);
    v_active = (v_cnt_q < V_VIS_C);
    h_last   = (h_cnt_q == H_LAST);
    v_last   = (v_cnt_q == V_LAST);

    h_cnt_d = h_last ? 12'd0 : h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      v_cnt_d = v_last ? 12'd0 : v_cnt_q + 12'd1;
    end

    // Everything registered below is decoded from the pre-edge counters so
    // rgb and both syncs leave the block on the same clock.
    rgb_d   = (h_active && v_active) ? color_in : 3'b000;
    hsync_d = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    tick_d  = h_last && (v_cnt_q == V_TICK);
  end

  always_ff @(posedge CLOCK_25 or posedge RESET) begin
    if (RESET) begin
      h_cnt_q <= 12'd0;
      v_cnt_q <= 12'd0;
      rgb_q   <= 3'b000;
      hsync_q <= ~SYNC_ACTIVE;
      vsync_q <= ~SYNC_ACTIVE;
      tick_q  <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      tick_q  <= tick_d;
    end
  end

  assign x          = h_active ? h_cnt_q + 12'd1 : 12'd0;
  assign y          = v_active ? v_cnt_q + 12'd1 : 12'd0;
  assign active     = h_active && v_active;
  assign rgb        = rgb_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_tick = tick_q;

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Produces the VGA raster for the Pong display: horizontal and vertical pixel counters, sync pulses and the 1-based pixel coordinates x and y consumed by img_generator.
- Takes img_generator's combinational color back and registers it to the DAC pins, blanked outside the visible area and aligned with the syncs.
- Emits a once-per-frame tick so game logic can update positions during vertical blanking.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch, in clocks
- H_SYNC, 96, horizontal sync width, in clocks
- H_BACK, 48, horizontal back porch, in clocks; H_TOTAL = 800
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch, in lines
- V_SYNC, 2, vertical sync width, in lines
- V_BACK, 33, vertical back porch, in lines; V_TOTAL = 525
- SYNC_ACTIVE, 0, asserted level of hsync and vsync (0 = active-low)

Ports:
- CLOCK_25  in  1  25 MHz pixel clock; the only clock
- RESET  in  1  asynchronous, active-high reset
- color_in  in  3  pixel color from img_generator for the current x,y; bit2 R, bit1 G, bit0 B
- x  out  12  1-based column: 1..H_VISIBLE when visible, 0 when blanked
- y  out  12  1-based row: 1..V_VISIBLE when visible, 0 when blanked
- active  out  1  high while h_cnt < H_VISIBLE and v_cnt < V_VISIBLE
- rgb  out  3  registered, blanked pixel color to the DAC
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync
- frame_tick  out  1  one-cycle pulse once per frame

Behaviour:
- Internal counters
  - h_cnt, 0..H_TOTAL-1; v_cnt, 0..V_TOTAL-1; both 12-bit registers.
  - Every clock: h_cnt increments. At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1, both counters wrap to 0 in the same clock.
  - Counter values outside their range never occur.
- x, y and active are decoded combinationally from the counter registers, with no added delay.
  - x = h_cnt+1 when h_cnt < H_VISIBLE, else 0.
  - y = v_cnt+1 when v_cnt < V_VISIBLE, else 0.
  - active and x/y blanking are evaluated independently per axis: x can be nonzero while y = 0 during vertical blank, and active is then 0.
- Registered outputs have 1-clock latency. On each clock edge, from the pre-edge counters:
  - rgb <= active ? color_in : 3'b000
  - hsync <= SYNC_ACTIVE when H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751), else ~SYNC_ACTIVE
  - vsync <= SYNC_ACTIVE when V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC (490..491), else ~SYNC_ACTIVE
  - frame_tick <= (h_cnt == H_TOTAL-1) && (v_cnt == V_VISIBLE-1)
- Result: rgb, hsync and vsync are mutually aligned. frame_tick is high for exactly the first clock in which the counters read (0, V_VISIBLE), i.e. the start of vertical blank, once per H_TOTAL*V_TOTAL = 420000 clocks.
- color_in is sampled only while active; its value during blanking is ignored.
- Reset, asynchronous and effective immediately, including mid-line or mid-frame:
  - h_cnt = 0, v_cnt = 0, so x = 1, y = 1, active = 1 while RESET is held.
  - rgb = 3'b000, hsync = vsync = ~SYNC_ACTIVE, frame_tick = 0.
  - The first clock after release starts pixel (1,1) of a fresh frame. No partial sync pulse or tick is generated by the abort.
- Simultaneous events: the frame_tick condition and the horizontal wrap occur in the same clock by design, and both take effect. Counters have no enable, so there is no stall condition.

Test Plan:
- Reset behaviour: assert RESET for 5 clocks mid-frame, at h_cnt = 300, v_cnt = 200 -> immediately x = 1, y = 1, rgb = 0, hsync = vsync = 1, frame_tick = 0. After release, x counts 1,2,3... on successive clocks.
- Horizontal timing: run one line from reset -> x = 640 at clock 639, x = 0 at clock 640. hsync goes low at the edge after h_cnt = 656, stays low for exactly 96 clocks, and the line repeats with a period of 800.
- Blanking: hold color_in = 3'b111 -> rgb = 3'b111 for 640 consecutive clocks, then 3'b000 for 160 clocks per visible line. rgb = 3'b000 for all of lines 481..525.
- Vertical timing and tick: run 2 full frames -> vsync low for exactly 1600 clocks starting one clock after (h_cnt = 0, v_cnt = 490). frame_tick pulses are exactly 420000 clocks apart, each 1 clock wide, and the first arrives one clock after (h_cnt = 799, v_cnt = 479).
- Coordinate corners: check (x,y) = (1,1) at counters (0,0), (640,480) at counters (639,479), and (0,0) at counters (640,480). Wrap from counters (799,524) to (0,0) gives x = 1, y = 1.
- Color alignment: drive color_in = 3'b010 only when x == 1 or y == 1 -> rgb shows 3'b010 on the first column and first row, each one clock after the corresponding counter value, in phase with hsync and vsync.
